iobuf_halfduplex_ctrl: RTL and testbench

- Half-duplex single-wire transaction engine sitting directly upstream of a tri-state I/O pad buffer.
- Drives the buffer's data input and tristate control, and samples the buffer's input-return path.
- Serializes a parallel word onto the pad, LSB first, then optionally releases the pad for a turnaround gap and reads back a word of the same width.
- Presents valid/ready on the transmit side and a one-cycle valid pulse on the receive side.

---
 rtl/iobuf_ctrl_pkg.sv | 26 ++
 rtl/pad_sync.sv | 20 ++
 rtl/iobuf_halfduplex_ctrl.sv | 175 +++++++++++++++++
 tb/tb_iobuf_halfduplex_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/iobuf_ctrl_pkg.sv
// Shared types and helpers for the half-duplex pad transaction engine.
package iobuf_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_TURN,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < n) begin
         p = p << 1;
         r++;
      end
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/pad_sync.sv
// Flop-chain synchronizer for the asynchronous pad return path; clears to 1.
module pad_sync #(
   parameter int unsigned SYNC = 2
) (
   input  logic C,
   input  logic CLR_N,
   input  logic pad_o,
   output logic pad_o_sync
);

   logic [SYNC-1:0] stages;

   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) stages <= '1;
      else        stages <= {stages[SYNC-2:0], pad_o};
   end

   assign pad_o_sync = stages[SYNC-1];

endmodule

// File: rtl/iobuf_halfduplex_ctrl.sv
// Half-duplex single-wire engine: drives a word LSB first, optionally turns
// the pad around and reads a word back. All outputs are registered.
module iobuf_halfduplex_ctrl
   import iobuf_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIV   = 4,
   parameter int unsigned TURN  = 2,
   parameter int unsigned SYNC  = 2
) (
   input  logic             C,
   input  logic             CLR_N,
   input  logic             TX_VALID,
   output logic             TX_READY,
   input  logic [WIDTH-1:0] TX_DATA,
   input  logic             RX_EN,
   output logic             RX_VALID,
   output logic [WIDTH-1:0] RX_DATA,
   output logic             BUSY,
   output logic             PAD_I,
   output logic             PAD_T,
   input  logic             PAD_O
);

   localparam int unsigned DIV_W = clog2(DIV);
   localparam int unsigned BIT_W = clog2(WIDTH);
   localparam int unsigned TRN_W = clog2(TURN * DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [TRN_W-1:0] TRN_LAST = TRN_W'(TURN * DIV - 1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [TRN_W-1:0] trn_q, trn_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic             rx_en_q, rx_en_d;
   logic             pad_t_q, pad_t_d;
   logic             pad_i_q, pad_i_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;
   logic             rx_valid_q, rx_valid_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             pad_o_s;
   logic             div_wrap;
   logic             word_end;

   pad_sync #(.SYNC(SYNC)) u_pad_sync (
      .C          (C),
      .CLR_N      (CLR_N),
      .pad_o      (PAD_O),
      .pad_o_sync (pad_o_s)
   );

   assign div_wrap = (div_q == DIV_LAST);
   assign word_end = div_wrap && (bit_q == BIT_LAST);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      trn_d      = trn_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_en_d    = rx_en_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (TX_VALID && tx_ready_q) begin
               state_d = ST_DRIVE;
               tx_sh_d = TX_DATA;
               rx_en_d = RX_EN;
               div_d   = '0;
               bit_d   = '0;
            end
         end
         ST_DRIVE: begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (word_end) begin
               state_d = rx_en_q ? ST_TURN : ST_IDLE;
               bit_d   = '0;
               trn_d   = '0;
            end else if (div_wrap) begin
               bit_d   = bit_q + 1'b1;
               tx_sh_d = tx_sh_q >> 1;
            end
         end
         ST_TURN: begin
            if (trn_q == TRN_LAST) begin
               state_d = ST_SAMPLE;
               trn_d   = '0;
               div_d   = '0;
               bit_d   = '0;
            end else begin
               trn_d = trn_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            div_d = div_wrap ? '0 : div_q + 1'b1;
            if (div_q == DIV_MID) rx_sh_d[bit_q] = pad_o_s;
            // With DIV=2 the last capture lands on the closing edge, so publish rx_sh_d.
            if (word_end) begin
               state_d    = ST_DONE;
               rx_data_d  = rx_sh_d;
               rx_valid_d = 1'b1;
               bit_d      = '0;
            end else if (div_wrap) begin
               bit_d = bit_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            div_d   = '0;
            bit_d   = '0;
            trn_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            div_d   = '0;
            bit_d   = '0;
            trn_d   = '0;
         end
      endcase

      pad_t_d    = (state_d != ST_DRIVE);
      pad_i_d    = (state_d == ST_DRIVE) ? tx_sh_d[0] : 1'b0;
      tx_ready_d = (state_d == ST_IDLE);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge C or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q    <= ST_IDLE;
         div_q      <= '0;
         bit_q      <= '0;
         trn_q      <= '0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_en_q    <= 1'b0;
         pad_t_q    <= 1'b1;
         pad_i_q    <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         trn_q      <= trn_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_en_q    <= rx_en_d;
         pad_t_q    <= pad_t_d;
         pad_i_q    <= pad_i_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign TX_READY = tx_ready_q;
   assign BUSY     = busy_q;
   assign PAD_T    = pad_t_q;
   assign PAD_I    = pad_i_q;
   assign RX_VALID = rx_valid_q;
   assign RX_DATA  = rx_data_q;

endmodule

// File: tb/tb_iobuf_halfduplex_ctrl.sv
// Randomized bench for iobuf_halfduplex_ctrl against a cycle-offset reference model.
module tb_iobuf_halfduplex_ctrl;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int T  = 2;
   localparam int WS = W * D;
   localparam int TS = (W + T) * D;
   localparam int DS = (2 * W + T) * D;

   logic       C, CLR_N;
   logic       tx_valid, rx_en, pad_o;
   logic [7:0] tx_data;
   logic       TX_READY, RX_VALID, BUSY, PAD_I, PAD_T;
   logic [7:0] RX_DATA;

   logic       tx_valid_s, rx_en_s, pad_s;
   logic [0:0] tx_data_s, rx_data_s;
   logic       tx_ready_s, rx_valid_s, busy_s, pad_i_s, pad_t_s;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   bit         m_active;
   bit         m_rxen;
   int         m_k;
   logic [7:0] m_data, m_pad, m_rxdata, cur_pad;
   bit         b2b_mode;
   int         last_acc;

   iobuf_halfduplex_ctrl #(.WIDTH(8), .DIV(4), .TURN(2), .SYNC(2)) u_dut (
      .C(C), .CLR_N(CLR_N), .TX_VALID(tx_valid), .TX_READY(TX_READY),
      .TX_DATA(tx_data), .RX_EN(rx_en), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
      .BUSY(BUSY), .PAD_I(PAD_I), .PAD_T(PAD_T), .PAD_O(pad_o)
   );

   iobuf_halfduplex_ctrl #(.WIDTH(1), .DIV(2), .TURN(1), .SYNC(2)) u_small (
      .C(C), .CLR_N(CLR_N), .TX_VALID(tx_valid_s), .TX_READY(tx_ready_s),
      .TX_DATA(tx_data_s), .RX_EN(rx_en_s), .RX_VALID(rx_valid_s), .RX_DATA(rx_data_s),
      .BUSY(busy_s), .PAD_I(pad_i_s), .PAD_T(pad_t_s), .PAD_O(pad_s)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: advance the model with the inputs present at the edge, then compare.
   task automatic tick();
      logic e_t, e_i, e_r, e_b, e_v;
      @(posedge C);
      #1;
      cyc++;
      if (m_active) begin
         m_k++;
         if ((!m_rxen && m_k == WS) || (m_rxen && m_k == DS + 1)) m_active = 0;
         else if (m_rxen && m_k == DS) m_rxdata = m_pad;
      end else if (tx_valid && CLR_N) begin
         m_active = 1;
         m_k      = 0;
         m_data   = tx_data;
         m_rxen   = rx_en;
         m_pad    = cur_pad;
         if (b2b_mode && last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 33);
         last_acc = cyc;
      end
      e_t = 1; e_i = 0; e_r = 1; e_b = 0; e_v = 0;
      if (m_active) begin
         e_r = 0;
         e_b = 1;
         if (m_k < WS) begin
            e_t = 0;
            e_i = m_data[m_k / D];
         end
         if (m_k == DS) e_v = 1;
      end
      chk("pad_t",    PAD_T,    e_t);
      chk("pad_i",    PAD_I,    e_i);
      chk("tx_ready", TX_READY, e_r);
      chk("busy",     BUSY,     e_b);
      chk("rx_valid", RX_VALID, e_v);
      chk("rx_data",  RX_DATA,  m_rxdata);
      if (m_active && m_rxen && m_k >= TS && m_k < DS) pad_o = m_pad[(m_k - TS) / D];
      else pad_o = 1'($urandom_range(0, 1));
   endtask

   // mode 0: quiet, 1: one 0xFF request mid-drive, 2: random requests while driving
   task automatic send(input logic [7:0] d, input bit re, input logic [7:0] p, input int mode);
      tx_valid = 1;
      tx_data  = d;
      rx_en    = re;
      cur_pad  = p;
      tick();
      tx_valid = 0;
      for (int n = 0; n < 200 && m_active; n++) begin
         tx_valid = 0;
         if (m_k + 3 < WS) begin
            if (mode == 1 && m_k == 10) begin
               tx_valid = 1;
               tx_data  = 8'hFF;
            end else if (mode == 2) begin
               tx_valid = 1'($urandom_range(0, 1));
               tx_data  = 8'($urandom);
               rx_en    = 1'($urandom_range(0, 1));
            end
         end
         tick();
      end
      chk("txn_end_ready", TX_READY, 1);
   endtask

   initial begin
      CLR_N = 0; tx_valid = 0; tx_data = '0; rx_en = 0; pad_o = 0;
      tx_valid_s = 0; tx_data_s = '0; rx_en_s = 0; pad_s = 1;
      m_active = 0; m_rxen = 0; m_k = 0; m_data = '0; m_pad = '0;
      m_rxdata = '0; cur_pad = '0; b2b_mode = 0; last_acc = -1;

      repeat (3) @(posedge C);
      #1;
      chk("rst_pad_t",    PAD_T,    1);
      chk("rst_pad_i",    PAD_I,    0);
      chk("rst_tx_ready", TX_READY, 1);
      chk("rst_busy",     BUSY,     0);
      chk("rst_rx_valid", RX_VALID, 0);
      chk("rst_rx_data",  RX_DATA,  8'h00);
      CLR_N = 1;
      repeat (2) tick();

      tx_valid_s = 1; rx_en_s = 1; tx_data_s = 1'b1;
      tick();
      tx_valid_s = 0;
      chk("s_accept_pad_t", pad_t_s, 0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("s_rx_valid", rx_valid_s, (k == 6) ? 1 : 0);
         if (k == 6) chk("s_rx_data", rx_data_s, 1);
      end
      chk("s_tx_ready", tx_ready_s, 1);

      send(8'hA5, 0, 8'h00, 0);
      send(8'h3C, 1, 8'h5A, 0);
      send(8'hA5, 0, 8'h00, 1);

      b2b_mode = 1;
      last_acc = -1;
      tx_valid = 1;
      rx_en    = 0;
      for (int n = 0; n < 3 * 33 + 2; n++) begin
         tx_data = 8'($urandom);
         tick();
      end
      tx_valid = 0;
      for (int n = 0; n < 100 && m_active; n++) tick();
      chk("b2b_end_ready", TX_READY, 1);
      b2b_mode = 0;

      for (int t = 0; t < 20; t++) begin
         repeat ($urandom_range(0, 3)) tick();
         send(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 2);
      end

      tx_valid = 1; tx_data = 8'($urandom); rx_en = 1; cur_pad = 8'($urandom);
      tick();
      tx_valid = 0;
      repeat (9) tick();
      #2;
      CLR_N = 0;
      #1;
      chk("midrst_pad_t",    PAD_T,    1);
      chk("midrst_pad_i",    PAD_I,    0);
      chk("midrst_busy",     BUSY,     0);
      chk("midrst_tx_ready", TX_READY, 1);
      chk("midrst_rx_data",  RX_DATA,  8'h00);
      m_active = 0;
      m_rxdata = '0;
      repeat (2) tick();
      CLR_N = 1;
      repeat (80) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
